seq_mult_q: RTL and testbench

//  Parametrised sequential signed shift-add multiplier for the FFT butterfly datapath.

---
 rtl/seq_mult_q.sv | 154 +++++++++++++++
 tb/tb_seq_mult_q.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_q.sv
// Sequential signed shift-add multiplier: one partial-product bit per clock, followed by
// a rounded and optionally saturated WIDTH-bit Q-format result for twiddle scaling.
module seq_mult_q #(
    parameter int WIDTH     = 8,
    parameter int FRAC_BITS = 7,
    parameter int ROUND     = 1,
    parameter int SATURATE  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   input_0,
    input  logic [WIDTH-1:0]   input_1,
    output logic               busy,
    output logic               data_valid,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   out_q,
    output logic               sat
);
    localparam int PW     = 2 * WIDTH;
    localparam int CW     = $clog2(WIDTH);
    localparam int RND_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
    localparam logic signed [PW:0] RND_ONE = {{PW{1'b0}}, 1'b1};
    localparam logic signed [PW:0] RND_C   = (ROUND != 0 && FRAC_BITS > 0) ? (RND_ONE <<< RND_SH) : '0;
    localparam logic signed [PW:0] Q_MAX   = {{(PW - WIDTH + 2){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [PW:0] Q_MIN   = {{(PW - WIDTH + 2){1'b1}}, {(WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_load;
    logic              w_step;
    logic              w_finish;
    logic              w_busy;
    logic              w_last;

    logic [WIDTH-1:0]  r_a;
    logic [PW-1:0]     r_b;
    logic [PW-1:0]     r_acc;
    logic [CW-1:0]     r_cnt;
    logic [PW-1:0]     w_pp;

    logic              r_valid;
    logic [PW-1:0]     r_product;
    logic [WIDTH-1:0]  r_out_q;
    logic              r_sat;

    logic signed [PW:0] w_r;
    logic signed [PW:0] w_s;
    logic [WIDTH-1:0]   w_q;
    logic               w_sat;

    assign w_last = (r_cnt == CW'(WIDTH - 1));
    assign w_pp   = r_b << r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_MULT;
            S_MULT:  if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_finish = 1'b0;
        w_busy   = 1'b0;
        case (r_state)
            S_IDLE: w_load = start;
            S_MULT: begin
                w_busy = 1'b1;
                w_step = 1'b1;
            end
            S_DONE: begin
                w_busy   = 1'b1;
                w_finish = 1'b1;
            end
            default: ;
        endcase
    end

    // The MSB of a carries negative weight, so the final iteration subtracts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_a   <= input_0;
            r_b   <= {{WIDTH{input_1[WIDTH-1]}}, input_1};
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_step) begin
            if (r_a[r_cnt]) begin
                r_acc <= w_last ? (r_acc - w_pp) : (r_acc + w_pp);
            end
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // One guard bit keeps the rounding add from overflowing at the most positive product.
    assign w_r = $signed({r_acc[PW-1], r_acc}) + RND_C;
    assign w_s = w_r >>> FRAC_BITS;

    always_comb begin
        w_q   = w_s[WIDTH-1:0];
        w_sat = 1'b0;
        if (SATURATE != 0) begin
            if (w_s > Q_MAX) begin
                w_q   = Q_MAX[WIDTH-1:0];
                w_sat = 1'b1;
            end else if (w_s < Q_MIN) begin
                w_q   = Q_MIN[WIDTH-1:0];
                w_sat = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_product <= '0;
            r_out_q   <= '0;
            r_sat     <= 1'b0;
        end else begin
            r_valid <= w_finish;
            if (w_finish) begin
                r_product <= r_acc;
                r_out_q   <= w_q;
                r_sat     <= w_sat;
            end
        end
    end

    assign busy       = w_busy;
    assign data_valid = r_valid;
    assign product    = r_product;
    assign out_q      = r_out_q;
    assign sat        = r_sat;

endmodule

// File: tb/tb_seq_mult_q.sv
// Bench for seq_mult_q: directed and random products against an integer-arithmetic model,
// with a second instance (no rounding, wrap) covering the alternate scaling modes.
module tb_seq_mult_q;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in0 = '0;
    logic [7:0]  in1 = '0;
    logic        busy, dv, sat;
    logic [15:0] prod;
    logic [7:0]  outq;
    logic        busy2, dv2, sat2;
    logic [15:0] prod2;
    logic [7:0]  outq2;

    int checks = 0;
    int errors = 0;

    seq_mult_q #(.WIDTH(8), .FRAC_BITS(7), .ROUND(1), .SATURATE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .input_0(in0), .input_1(in1),
        .busy(busy), .data_valid(dv), .product(prod), .out_q(outq), .sat(sat)
    );

    seq_mult_q #(.WIDTH(8), .FRAC_BITS(7), .ROUND(0), .SATURATE(0)) dut_nr (
        .clk(clk), .rst_n(rst_n), .start(start), .input_0(in0), .input_1(in1),
        .busy(busy2), .data_valid(dv2), .product(prod2), .out_q(outq2), .sat(sat2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input int a, input int b, input bit rnd, input bit sat_en,
                                  output logic [15:0] p, output logic [7:0] q, output logic s);
        longint pr, sh;
        pr = longint'(a) * longint'(b);
        p  = pr[15:0];
        sh = (pr + (rnd ? 64 : 0)) >>> 7;
        s  = 1'b0;
        if (sat_en && sh > 127) begin
            sh = 127;
            s  = 1'b1;
        end else if (sat_en && sh < -128) begin
            sh = -128;
            s  = 1'b1;
        end
        q = sh[7:0];
    endfunction

    task automatic run_op(input int a, input int b, input bit noise);
        logic [15:0] ep, ep2;
        logic [7:0]  eq, eq2;
        logic        es, es2;
        int k, nb;
        model(a, b, 1'b1, 1'b1, ep, eq, es);
        model(a, b, 1'b0, 1'b0, ep2, eq2, es2);
        @(negedge clk);
        in0 = 8'(a);
        in1 = 8'(b);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        nb = 0;
        while (!dv && k < 20) begin
            if (busy) nb++;
            if (noise) begin
                start = (k == 3 || k == 8);
                in0 = 8'($urandom);
                in1 = 8'($urandom);
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        $display("op a=%0d b=%0d noise=%0b latency=%0d product=%h out_q=%h sat=%0b out_q_nr=%h",
                 a, b, noise, k, prod, outq, sat, outq2);
        check("latency", k, 9);
        check("busy_len", nb, 9);
        check("product", prod, ep);
        check("out_q", outq, eq);
        check("sat", sat, es);
        check("product_nr", prod2, ep2);
        check("out_q_nr", outq2, eq2);
        check("sat_nr", sat2, es2);
        @(negedge clk);
        check("dv_pulse", dv, 1'b0);
    endtask

    initial begin
        int ah[3], bh[3];
        int k, idx, nd;
        logic [15:0] ep;
        logic [7:0]  eq;
        logic        es;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_dv", dv, 1'b0);
        check("rst_product", prod, 16'h0000);
        check("rst_out_q", outq, 8'h00);
        check("rst_sat", sat, 1'b0);
        rst_n = 1'b1;

        run_op(3, 5, 1'b0);
        check("3x5", prod, 16'h000F);
        run_op(-2, 7, 1'b0);
        check("m2x7", prod, 16'hFFF2);
        run_op(7, -2, 1'b0);
        check("7xm2", prod, 16'hFFF2);
        run_op(-128, 127, 1'b0);
        check("m128x127_q", outq, 8'h81);
        run_op(-128, -128, 1'b0);
        check("m128sq_sat", sat, 1'b1);
        check("m128sq_q", outq, 8'h7F);
        check("m128sq_wrap", outq2, 8'h80);
        run_op(3, 21, 1'b0);
        check("round63", outq, 8'h00);
        run_op(3, 22, 1'b0);
        check("round66", outq, 8'h01);
        run_op(64, 64, 1'b0);
        check("trunc4096", outq2, 8'd32);
        run_op(0, -77, 1'b0);
        run_op(-1, -1, 1'b1);

        for (int i = 0; i < 12; i++) begin
            run_op(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                   1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 3; i++) begin
            ah[i] = int'($urandom_range(0, 255)) - 128;
            bh[i] = int'($urandom_range(0, 255)) - 128;
        end
        @(negedge clk);
        in0 = 8'(ah[0]);
        in1 = 8'(bh[0]);
        start = 1'b1;
        @(negedge clk);
        k = 0;
        idx = 0;
        while (k < 30) begin
            if (dv) begin
                if (idx < 3) begin
                    model(ah[idx], bh[idx], 1'b1, 1'b1, ep, eq, es);
                    $display("stream op=%0d at=%0d product=%h expected=%h", idx, k, prod, ep);
                    check("stream_at", k, 9 + 10 * idx);
                    check("stream_product", prod, ep);
                end
                idx++;
            end
            if (k == 29) begin
                start = 1'b0;
            end else if ((k + 1) % 10 == 0) begin
                in0 = 8'(ah[(k + 1) / 10]);
                in1 = 8'(bh[(k + 1) / 10]);
            end else begin
                in0 = 8'($urandom);
                in1 = 8'($urandom);
            end
            @(negedge clk);
            k++;
        end
        check("stream_count", idx, 3);

        run_op(100, 100, 1'b0);
        @(negedge clk);
        in0 = 8'd55;
        in1 = 8'd33;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("mid-op reset busy=%0b dv=%0b product=%h out_q=%h sat=%0b", busy, dv, prod, outq, sat);
        check("midrst_busy", busy, 1'b0);
        check("midrst_dv", dv, 1'b0);
        check("midrst_product", prod, 16'h0000);
        check("midrst_out_q", outq, 8'h00);
        check("midrst_sat", sat, 1'b0);
        nd = 0;
        repeat (15) begin
            @(negedge clk);
            if (dv) nd++;
        end
        check("midrst_no_dv", nd, 0);
        run_op(10, -10, 1'b0);
        check("after_rst", prod, 16'hFF9C);

        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        in0 = 8'd5;
        in1 = 8'd5;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        $display("reset+start busy=%0b", busy);
        check("rst_start_busy", busy, 1'b0);
        @(negedge clk);
        check("rst_start_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
